sprite_ram_arbiter: RTL and testbench

Controller for the 1K x 16 sprite RAM (`ramsprite`), replacing the ad-hoc write/read address mux. After reset or on command, it sequences a full sprite load from an initialisation source, such as the `$readmemb` ROM of the snowman bitmap, into the RAM. Between loads it shares the RAM read port round-robin between two requesters: the VGA sprite plotter and the collision checker.

---
 rtl/sprite_ram_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 49 ++++
 rtl/sprite_ram_arbiter.sv | 169 ++++++++++++++++
 tb/tb_sprite_ram_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_ram_pkg.sv
// Shared constants and FSM state type for the sprite RAM controller.
//   DFLT_ADDR_W / DFLT_DATA_W : default RAM geometry (1K x 16)
//   SPRITE_W x SPRITE_H       : sprite bitmap size, DFLT_SPRITE_PIXELS words
package sprite_ram_pkg;

  localparam int unsigned DFLT_ADDR_W        = 10;
  localparam int unsigned DFLT_DATA_W        = 16;
  localparam int unsigned SPRITE_W           = 20;
  localparam int unsigned SPRITE_H           = 40;
  localparam int unsigned DFLT_SPRITE_PIXELS = SPRITE_W * SPRITE_H;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } load_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with combinational grant.
//   clk, reset : clock, async active-high reset
//   req[1:0]   : requests
//   en         : grant enable; gnt is zero when low
//   gnt[1:0]   : one-hot or zero grant
// The pointer moves past whichever requester was granted, so the other
// side wins the next tie. After reset a tie goes to req[0].
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic ptr_q;
  logic ptr_d;

  // Grant selection: single requester always wins, ties follow the pointer
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = ptr_q ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
  end

  // Pointer update on any grant
  always_comb begin
    ptr_d = ptr_q;
    if (gnt[0]) begin
      ptr_d = 1'b1;
    end else if (gnt[1]) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sprite_ram_arbiter.sv
// Sprite RAM controller: sequences a full sprite load from an init source
// into the RAM, and between loads shares the RAM read port round-robin
// between two readers (sprite plotter, collision checker).
// Ports:
//   clk, reset            : clock, async active-high reset
//   start_load            : request a (re)load, honoured only in IDLE
//   src_addr / src_data   : init source address out, data in one cycle later
//   reqN / addrN / gntN   : read request, address, combinational grant
//   rvalidN / rdata       : read strobe two cycles after grant, data from ram_q
//   ram_addr/ram_wdata/ram_wren/ram_q : registered RAM port and RAM output
//   load_busy, load_done, sprite_valid : load status
// Build option: define SPRITE_AUTOLOAD_EN to start a load automatically in
// the first cycle after reset is released.
module sprite_ram_arbiter
  import sprite_ram_pkg::*;
#(
  parameter int unsigned ADDR_W        = DFLT_ADDR_W,
  parameter int unsigned DATA_W        = DFLT_DATA_W,
  parameter int unsigned SPRITE_PIXELS = DFLT_SPRITE_PIXELS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_load,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0] src_data,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              load_busy,
  output logic              load_done,
  output logic              sprite_valid
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SPRITE_PIXELS - 1);

  load_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              wr_pend_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              ram_wren_q;
  logic [1:0]        rv1_q, rv2_q;
  logic              load_busy_q, load_done_q, sprite_valid_q;
  logic              start_c;
  logic              arb_en_c;
  logic [1:0]        gnt_c;

`ifdef SPRITE_AUTOLOAD_EN
  // Set by reset, cleared by the first clock: acts as a one-shot start_load
  logic auto_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      auto_q <= 1'b1;
    end else begin
      auto_q <= 1'b0;
    end
  end
  assign start_c = start_load | auto_q;
`else
  assign start_c = start_load;
`endif

  // Reads are served only in IDLE, and a load request wins that cycle
  assign arb_en_c = (state_q == IDLE) && !start_c && !reset;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({req1, req0}),
    .en    (arb_en_c),
    .gnt   (gnt_c)
  );

  // Next-state and load counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_c) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, write pipeline, read port and status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      wr_pend_q      <= 1'b0;
      wr_addr_q      <= '0;
      ram_addr_q     <= '0;
      ram_wdata_q    <= '0;
      ram_wren_q     <= 1'b0;
      rv1_q          <= 2'b00;
      rv2_q          <= 2'b00;
      load_busy_q    <= 1'b0;
      load_done_q    <= 1'b0;
      sprite_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      // src_addr issued this cycle returns data next cycle
      wr_pend_q <= (state_q == LOAD);
      wr_addr_q <= cnt_q;
      // Writes and grants never overlap: writes only follow LOAD cycles
      if (wr_pend_q) begin
        ram_addr_q  <= wr_addr_q;
        ram_wdata_q <= src_data;
        ram_wren_q  <= 1'b1;
      end else begin
        ram_wren_q <= 1'b0;
        if (gnt_c[0]) begin
          ram_addr_q <= addr0;
        end else if (gnt_c[1]) begin
          ram_addr_q <= addr1;
        end
      end
      rv1_q       <= gnt_c;
      rv2_q       <= rv1_q;
      load_busy_q <= (state_d != IDLE);
      load_done_q <= (state_q == DONE);
      if ((state_q == IDLE) && start_c) begin
        sprite_valid_q <= 1'b0;
      end else if (state_q == DONE) begin
        sprite_valid_q <= 1'b1;
      end
    end
  end

  assign src_addr     = cnt_q;
  assign gnt0         = gnt_c[0];
  assign gnt1         = gnt_c[1];
  assign rvalid0      = rv2_q[0];
  assign rvalid1      = rv2_q[1];
  assign rdata        = ram_q;
  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = ram_wdata_q;
  assign ram_wren     = ram_wren_q;
  assign load_busy    = load_busy_q;
  assign load_done    = load_done_q;
  assign sprite_valid = sprite_valid_q;

endmodule

// File: tb/tb_sprite_ram_arbiter.sv
// Directed bench for sprite_ram_arbiter with a behavioural init ROM
// (word = 16'hA000 + addr) and a 1K x 16 RAM with one-cycle read latency.
module tb_sprite_ram_arbiter;

  localparam int N = 800;

  logic        clk;
  logic        reset;
  logic        start_load;
  logic [9:0]  src_addr;
  logic [15:0] src_data;
  logic        req0, req1;
  logic [9:0]  addr0, addr1;
  logic        gnt0, gnt1;
  logic        rvalid0, rvalid1;
  logic [15:0] rdata;
  logic [9:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_wren;
  logic [15:0] ram_q;
  logic        load_busy, load_done, sprite_valid;

  logic [15:0] mem [0:1023];

  int n_cmp;
  int n_err;

  sprite_ram_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .start_load   (start_load),
    .src_addr     (src_addr),
    .src_data     (src_data),
    .req0         (req0),
    .req1         (req1),
    .addr0        (addr0),
    .addr1        (addr1),
    .gnt0         (gnt0),
    .gnt1         (gnt1),
    .rvalid0      (rvalid0),
    .rvalid1      (rvalid1),
    .rdata        (rdata),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_wren     (ram_wren),
    .ram_q        (ram_q),
    .load_busy    (load_busy),
    .load_done    (load_done),
    .sprite_valid (sprite_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Init source ROM: data one cycle after address
  always @(posedge clk) src_data <= 16'(32'hA000 + 32'(src_addr));

  // Sprite RAM: registered read, synchronous write
  always @(posedge clk) begin
    ram_q <= mem[ram_addr];
    if (ram_wren) mem[ram_addr] <= ram_wdata;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Full load observed cycle by cycle; cycle 0 is the cycle whose closing
  // edge samples the start (start_load, or reset release in autoload builds)
  task automatic do_load(input bit hold_req1, input bit by_start);
    int wr_ok, wr_cnt, done_cnt, done_cyc, busy_bad, g1_first;
    wr_ok = 0; wr_cnt = 0; done_cnt = 0; done_cyc = -1; busy_bad = 0; g1_first = -1;
    @(negedge clk);
    if (by_start) start_load = 1'b1;
    else reset = 1'b0;
    req1  = hold_req1;
    addr1 = 10'd7;
    #1;
    chk("load_busy_c0", 64'(load_busy), 64'd0);
    if (hold_req1) chk("prio_gnt1_c0", 64'(gnt1), 64'd0);
    for (int c = 1; c <= N + 5; c++) begin
      @(negedge clk);
      start_load = 1'b0;
      if (c == N + 4) req1 = 1'b0;
      #1;
      if (ram_wren) begin
        if (ram_addr == 10'(wr_cnt) && ram_wdata == 16'(32'hA000 + wr_cnt) && c == wr_cnt + 3)
          wr_ok++;
        wr_cnt++;
      end
      if (load_done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (load_busy != (c <= N + 2)) busy_bad++;
      if (gnt1 && g1_first < 0) g1_first = c;
      if (c == 1) chk("src_addr_first", 64'(src_addr), 64'd0);
      if (c == N) chk("src_addr_last", 64'(src_addr), 64'(N - 1));
      if (c == N + 2) chk("sprite_valid_pre", 64'(sprite_valid), 64'd0);
      if (c == N + 3) chk("sprite_valid_set", 64'(sprite_valid), 64'd1);
      if (hold_req1 && c == N + 5) begin
        chk("prio_rvalid1", 64'({rvalid1, rvalid0}), 64'd2);
        chk("prio_rdata", 64'(rdata), 64'hA007);
      end
    end
    chk("load_writes_ok", 64'(wr_ok), 64'(N));
    chk("load_wren_cnt", 64'(wr_cnt), 64'(N));
    chk("load_done_cnt", 64'(done_cnt), 64'd1);
    chk("load_done_cyc", 64'(done_cyc), 64'(N + 3));
    chk("load_busy_bad", 64'(busy_bad), 64'd0);
    if (hold_req1) chk("prio_gnt1_first", 64'(g1_first), 64'(N + 3));
  endtask

  task automatic contention();
    logic [1:0] exp_g [8];
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1; addr0 = 10'd10; addr1 = 10'd20;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 6) begin req0 = 1'b0; req1 = 1'b0; end
      #1;
      exp_g[i] = (i < 6) ? ((i % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      chk($sformatf("cont_gnt_%0d", i), 64'({gnt1, gnt0}), 64'(exp_g[i]));
      if (i >= 2) begin
        chk($sformatf("cont_rv_%0d", i), 64'({rvalid1, rvalid0}), 64'(exp_g[i-2]));
        if (exp_g[i-2] != 2'b00)
          chk($sformatf("cont_data_%0d", i), 64'(rdata), exp_g[i-2][0] ? 64'hA00A : 64'hA014);
      end else begin
        chk($sformatf("cont_rv_%0d", i), 64'({rvalid1, rvalid0}), 64'd0);
      end
    end
  endtask

  task automatic single_reader();
    @(negedge clk);
    req0 = 1'b1; addr0 = 10'd5;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 4) req0 = 1'b0;
      #1;
      chk($sformatf("single_gnt0_%0d", i), 64'(gnt0), 64'(i < 4));
      chk($sformatf("single_rv0_%0d", i), 64'(rvalid0), 64'(i >= 2));
      if (i >= 2) chk($sformatf("single_data_%0d", i), 64'(rdata), 64'hA005);
    end
  endtask

  task automatic abort_load();
    int to;
    int done_n, sv_n, busy_n;
    @(negedge clk); start_load = 1'b1;
    @(negedge clk); start_load = 1'b0;
    to = 0;
    while (!(ram_wren === 1'b1 && ram_addr == 10'd300) && to < 1000) begin
      @(negedge clk);
      to++;
    end
    chk("abort_reached", 64'(to < 1000), 64'd1);
    reset = 1'b1;
    #1;
    chk("abort_outs", 64'({load_busy, load_done, sprite_valid, ram_wren, gnt0, gnt1,
                           rvalid0, rvalid1, ram_addr, ram_wdata, src_addr}), 64'd0);
    repeat (2) @(negedge clk);
`ifdef SPRITE_AUTOLOAD_EN
    do_load(1'b0, 1'b0);
`else
    @(negedge clk); reset = 1'b0;
    done_n = 0; sv_n = 0; busy_n = 0;
    repeat (900) begin
      @(negedge clk);
      done_n += int'(load_done);
      sv_n   += int'(sprite_valid);
      busy_n += int'(load_busy);
    end
    chk("abort_no_done", 64'(done_n), 64'd0);
    chk("abort_no_valid", 64'(sv_n), 64'd0);
    chk("abort_idle", 64'(busy_n), 64'd0);
    do_load(1'b0, 1'b1);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1; start_load = 1'b0;
    req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outs", 64'({load_busy, load_done, sprite_valid, ram_wren, gnt0, gnt1,
                           rvalid0, rvalid1, ram_addr, ram_wdata, src_addr}), 64'd0);
`ifdef SPRITE_AUTOLOAD_EN
    do_load(1'b0, 1'b0);
`else
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("idle_no_load", 64'({load_busy, sprite_valid}), 64'd0);
    req1 = 1'b1; addr1 = 10'd3;
    #1;
    chk("preload_gnt1", 64'({gnt1, gnt0}), 64'd2);
    @(negedge clk); req1 = 1'b0;
    do_load(1'b0, 1'b1);
`endif
    contention();
    single_reader();
    do_load(1'b1, 1'b1);
    abort_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
